// File: rtl/directory_set_access.sv
// Request-side sequencer for an 8-way directory. It reads one set, picks the hit or
// allocation way, hands the set to the select stage and writes back its next-state vector.
module directory_set_access #(
  parameter int CL_SIZE  = 4,
  parameter int TAG_SIZE = 18,
  parameter int SET_BITS = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [TAG_SIZE+SET_BITS-1:0] req_addr,
  input  logic [2:0]                   req_op,
  input  logic [1:0]                   req_src,
  input  logic [1:0]                   req_dest,
  output logic [TAG_SIZE-1:0]          sel_tag,
  output logic [TAG_SIZE*8-1:0]        sel_tag_state,
  output logic [CL_SIZE*8-1:0]         sel_data_state,
  output logic [2:0]                   sel_op,
  output logic [1:0]                   sel_src,
  output logic [1:0]                   sel_dest,
  input  logic [CL_SIZE*8-1:0]         sel_data_next,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_hit,
  output logic                         resp_full,
  output logic [2:0]                   resp_way,
  output logic [CL_SIZE-1:0]           resp_state
);

  localparam int NUM_SETS = 1 << SET_BITS;

  typedef enum logic [2:0] {IDLE, READ, EVAL, ALLOC, RESP} state_e;

  state_e                           state_q, state_d;
  logic [TAG_SIZE-1:0]              tag_q, tag_d;
  logic [SET_BITS-1:0]              set_q, set_d;
  logic [2:0]                       op_q, op_d;
  logic [1:0]                       src_q, src_d, dest_q, dest_d;
  logic [7:0][TAG_SIZE-1:0]         tag_buf_q, tag_buf_d;
  logic [7:0][CL_SIZE-1:0]          st_buf_q, st_buf_d;
  logic                             hit_q, hit_d, full_q, full_d, alloc_q, alloc_d;
  logic [2:0]                       way_q, way_d;
  logic [CL_SIZE-1:0]               resp_state_q, resp_state_d;
  logic                             tag_we, state_we;

  logic [7:0][TAG_SIZE-1:0]         tag_array_q   [NUM_SETS];
  logic [7:0][CL_SIZE-1:0]          state_array_q [NUM_SETS];

  // Lookup on the live arrays during READ; the set buffer is loaded at the same edge.
  logic       lk_hit, lk_free;
  logic [2:0] lk_way, lk_free_way;

  always_comb begin
    lk_hit      = 1'b0;
    lk_way      = '0;
    lk_free     = 1'b0;
    lk_free_way = '0;
    for (int i = 0; i < 8; i++) begin
      if (tag_array_q[set_q][i] == tag_q && state_array_q[set_q][i] != '0) begin
        lk_hit = 1'b1;
        lk_way = 3'(i);
      end
    end
    for (int i = 7; i >= 0; i--) begin
      if (state_array_q[set_q][i] == '0) begin
        lk_free     = 1'b1;
        lk_free_way = 3'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    tag_d        = tag_q;
    set_d        = set_q;
    op_d         = op_q;
    src_d        = src_q;
    dest_d       = dest_q;
    tag_buf_d    = tag_buf_q;
    st_buf_d     = st_buf_q;
    hit_d        = hit_q;
    full_d       = full_q;
    alloc_d      = alloc_q;
    way_d        = way_q;
    resp_state_d = resp_state_q;
    tag_we       = 1'b0;
    state_we     = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        tag_d        = req_addr[TAG_SIZE+SET_BITS-1:SET_BITS];
        set_d        = req_addr[SET_BITS-1:0];
        op_d         = req_op;
        src_d        = req_src;
        dest_d       = req_dest;
        hit_d        = 1'b0;
        full_d       = 1'b0;
        alloc_d      = 1'b0;
        way_d        = '0;
        resp_state_d = '0;
        state_d      = READ;
      end
      READ: begin
        tag_buf_d = tag_array_q[set_q];
        st_buf_d  = state_array_q[set_q];
        if (lk_hit) begin
          hit_d   = 1'b1;
          way_d   = lk_way;
          state_d = EVAL;
        end else if (lk_free) begin
          alloc_d = 1'b1;
          way_d   = lk_free_way;
          state_d = ALLOC;
        end else begin
          full_d  = 1'b1;
          way_d   = '0;
          state_d = RESP;
        end
      end
      ALLOC: begin
        tag_we           = 1'b1;
        tag_buf_d[way_q] = tag_q;
        state_d          = EVAL;
      end
      EVAL: begin
        state_we     = 1'b1;
        resp_state_d = sel_data_next[way_q*CL_SIZE +: CL_SIZE];
        state_d      = RESP;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      set_q        <= '0;
      op_q         <= '0;
      src_q        <= '0;
      dest_q       <= '0;
      tag_buf_q    <= '0;
      st_buf_q     <= '0;
      hit_q        <= 1'b0;
      full_q       <= 1'b0;
      alloc_q      <= 1'b0;
      way_q        <= '0;
      resp_state_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      tag_q        <= tag_d;
      set_q        <= set_d;
      op_q         <= op_d;
      src_q        <= src_d;
      dest_q       <= dest_d;
      tag_buf_q    <= tag_buf_d;
      st_buf_q     <= st_buf_d;
      hit_q        <= hit_d;
      full_q       <= full_d;
      alloc_q      <= alloc_d;
      way_q        <= way_d;
      resp_state_q <= resp_state_d;
    end
  end

  // NOTE: the arrays are flops, not RAM, because reset must invalidate every way at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        tag_array_q[s]   <= '0;
        state_array_q[s] <= '0;
      end
    end else begin
      if (tag_we)   tag_array_q[set_q][way_q] <= tag_q;
      if (state_we) state_array_q[set_q]      <= sel_data_next;
    end
  end

  // Invalid lanes read as ~tag so the select stage can only match the hit or allocated way.
  always_comb begin
    sel_tag_state = '0;
    for (int i = 0; i < 8; i++) begin
      if (state_q != IDLE && st_buf_q[i] == '0 && !(alloc_q && way_q == 3'(i)))
        sel_tag_state[i*TAG_SIZE +: TAG_SIZE] = ~tag_q;
      else
        sel_tag_state[i*TAG_SIZE +: TAG_SIZE] = tag_buf_q[i];
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign sel_tag        = tag_q;
  assign sel_data_state = st_buf_q;
  assign sel_op         = op_q;
  assign sel_src        = src_q;
  assign sel_dest       = dest_q;
  assign resp_hit       = hit_q;
  assign resp_full      = full_q;
  assign resp_way       = way_q;
  assign resp_state     = resp_state_q;

endmodule

// File: tb/tb_directory_set_access.sv
// Self-checking bench for directory_set_access: directed scenarios followed by random
// transactions, all compared against a per-set tag/state model held in plain arrays.
module tb_directory_set_access;
  localparam int C = 4;
  localparam int T = 18;
  localparam int S = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [T+S-1:0]   req_addr = '0;
  logic [2:0]       req_op = '0;
  logic [1:0]       req_src = '0;
  logic [1:0]       req_dest = '0;
  logic [T-1:0]     sel_tag;
  logic [T*8-1:0]   sel_tag_state;
  logic [C*8-1:0]   sel_data_state;
  logic [2:0]       sel_op;
  logic [1:0]       sel_src;
  logic [1:0]       sel_dest;
  logic [C*8-1:0]   sel_data_next = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic             resp_hit;
  logic             resp_full;
  logic [2:0]       resp_way;
  logic [C-1:0]     resp_state;

  directory_set_access #(.CL_SIZE(C), .TAG_SIZE(T), .SET_BITS(S)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_src(req_src), .req_dest(req_dest),
    .sel_tag(sel_tag), .sel_tag_state(sel_tag_state), .sel_data_state(sel_data_state),
    .sel_op(sel_op), .sel_src(sel_src), .sel_dest(sel_dest), .sel_data_next(sel_data_next),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_full(resp_full), .resp_way(resp_way), .resp_state(resp_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [T-1:0] tag_m [64][8];
  logic [C-1:0] st_m  [64][8];

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 8; w++) begin
        tag_m[s][w] = '0;
        st_m[s][w]  = '0;
      end
  endtask

  // One full request: predict from the model, drive, time the response, check, retire.
  task automatic do_txn(input logic [S-1:0] s, input logic [T-1:0] t,
                        input logic [C*8-1:0] nxt, input int hold);
    int hits[$];
    int frees[$];
    logic exp_hit, exp_full, alloc;
    int exp_way, exp_lat, cyc;
    logic [T*8-1:0] exp_ts, obs_ts;
    logic [C*8-1:0] exp_ds, obs_ds;
    logic [T-1:0] lane_tag;
    logic [2:0] op;
    logic [1:0] src, dst;
    for (int w = 0; w < 8; w++) begin
      if (st_m[s][w] != 0 && tag_m[s][w] == t) hits.push_back(w);
      if (st_m[s][w] == 0) frees.push_back(w);
    end
    exp_hit  = (hits.size() != 0);
    exp_full = !exp_hit && (frees.size() == 0);
    alloc    = !exp_hit && !exp_full;
    exp_way  = exp_hit ? hits[$] : (alloc ? frees[0] : 0);
    exp_lat  = exp_hit ? 3 : (exp_full ? 2 : 4);
    for (int w = 0; w < 8; w++) begin
      lane_tag = (alloc && w == exp_way) ? t : tag_m[s][w];
      exp_ts[w*T +: T] = (st_m[s][w] == 0 && !(alloc && w == exp_way)) ? ~t : lane_tag;
      exp_ds[w*C +: C] = st_m[s][w];
    end
    op  = 3'($urandom);
    src = 2'($urandom);
    dst = 2'($urandom);

    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid     = 1'b1;
    req_addr      = {t, s};
    req_op        = op;
    req_src       = src;
    req_dest      = dst;
    sel_data_next = nxt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc    = 1;
    obs_ts = '0;
    obs_ds = '0;
    while (!resp_valid && cyc < 20) begin
      obs_ts = sel_tag_state;
      obs_ds = sel_data_state;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("resp_latency", cyc, exp_lat);
    check("resp_hit", resp_hit, exp_hit);
    check("resp_full", resp_full, exp_full);
    check("resp_way", resp_way, exp_way);
    check("sel_tag", sel_tag, t);
    check("sel_fields", {sel_op, sel_src, sel_dest}, {op, src, dst});
    if (!exp_full) begin
      check("resp_state", resp_state, nxt[exp_way*C +: C]);
      check("eval_tag_lanes", obs_ts, exp_ts);
      check("eval_state_lanes", obs_ds, exp_ds);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_resp_valid", resp_valid, 1'b1);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_payload", {resp_hit, resp_full, resp_way}, {exp_hit, exp_full, 3'(exp_way)});
      if (!exp_full) check("bp_state", resp_state, nxt[exp_way*C +: C]);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_valid", resp_valid, 1'b0);
    check("post_hs_ready", req_ready, 1'b1);
    if (!exp_full) begin
      if (alloc) tag_m[s][exp_way] = t;
      for (int w = 0; w < 8; w++) st_m[s][w] = nxt[w*C +: C];
    end
  endtask

  initial begin
    logic [C*8-1:0] vec;
    int cyc;
    clear_model();

    // Outputs while reset is held
    #2;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp", {resp_valid, resp_hit, resp_full, resp_way, resp_state}, '0);
    check("rst_sel_tag", sel_tag, '0);
    check("rst_sel_tag_state", sel_tag_state, '0);
    check("rst_sel_data_state", sel_data_state, '0);
    check("rst_sel_fields", {sel_op, sel_src, sel_dest}, '0);
    @(negedge clk);
    rst = 1'b1;

    // Miss-allocate then hit on set 5
    do_txn(6'd5, 18'h1234, 32'h0000_0002, 0);
    do_txn(6'd5, 18'h1234, 32'h0000_0002, 0);

    // Masking: only way 2 valid with tag 0
    do_txn(6'd3, 18'h0, 32'h0000_0100, 0);
    do_txn(6'd3, 18'h0, 32'h0000_0100, 0);
    check("mask_way", resp_way, 3'd2);

    // Full set 9
    for (int i = 0; i < 8; i++) begin
      vec = '0;
      for (int w = 0; w <= i; w++) vec[w*C +: C] = 4'h1;
      do_txn(6'd9, 18'h100 + 18'(i), vec, 0);
    end
    do_txn(6'd9, 18'h200, 32'h1111_1111, 0);
    do_txn(6'd9, 18'h107, 32'h1111_1111, 0);

    // Backpressure on a hit
    do_txn(6'd5, 18'h1234, 32'h0000_0003, 5);

    // Two valid ways carrying the same tag
    do_txn(6'd12, 18'h0, 32'h0100_0010, 0);
    do_txn(6'd12, 18'h0, 32'h0100_0010, 0);
    check("multi_match_way", resp_way, 3'd6);

    // Reset in the middle of EVAL
    do_txn(6'd20, 18'h2AA, 32'h0000_0005, 0);
    @(negedge clk);
    req_valid     = 1'b1;
    req_addr      = {18'h2AA, 6'd20};
    sel_data_next = 32'h0000_0007;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    #1;
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    do_txn(6'd20, 18'h2AA, 32'h0000_0001, 0);
    check("midrst_realloc_way", {resp_hit, resp_way}, 4'b0_000);

    // Random traffic over a few sets and a small tag pool
    for (int n = 0; n < 150; n++) begin
      for (int w = 0; w < 8; w++)
        vec[w*C +: C] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      do_txn(6'(40 + $urandom_range(0, 3)), 18'($urandom_range(0, 5)), vec,
             int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/directory_set_access.md
# directory_set_access

Request-side sequencer for the directory. It accepts one coherence request at a time and reads the addressed set's 8 tag lanes and 8 state lanes from internal arrays. It presents them to the downstream way-select / next-state stage, which is combinational and fed through the `sel_*` ports. The returned per-set state vector is written back, a way is allocated on a miss, and the result is reported on a valid/ready response port.

## Interface
Parameters:
- `CL_SIZE`, 4, width of one way's coherence state; 0 means invalid.
- `TAG_SIZE`, 18, tag width.
- `SET_BITS`, 6, set index width; the block holds 2^SET_BITS sets × 8 ways.

Ports:
- `clk`, in, 1, single clock; all state changes on the rising edge.
- `rst`, in, 1, asynchronous, active-low reset.
- `req_valid`, in, 1, request present.
- `req_ready`, out, 1, block can accept a request.
- `req_addr`, in, `TAG_SIZE+SET_BITS`, `{tag, set}`; set = low `SET_BITS`.
- `req_op`, in, 3, operation code, passed through unmodified.
- `req_src`, in, 2, requester id.
- `req_dest`, in, 2, destination id.
- `sel_tag`, out, `TAG_SIZE`, latched request tag.
- `sel_tag_state`, out, `TAG_SIZE*8`, masked tag lanes; way i in bits `[i*TAG_SIZE +: TAG_SIZE]`.
- `sel_data_state`, out, `CL_SIZE*8`, state lanes of the set; way i in bits `[i*CL_SIZE +: CL_SIZE]`.
- `sel_op`, `sel_src`, `sel_dest`, out, 3/2/2, latched request fields.
- `sel_data_next`, in, `CL_SIZE*8`, next state vector from the select stage.
- `resp_valid`, out, 1, response present.
- `resp_ready`, in, 1, consumer accepts the response.
- `resp_hit`, out, 1, valid tag match found at lookup.
- `resp_full`, out, 1, miss with no invalid way; nothing written.
- `resp_way`, out, 3, way used.
- `resp_state`, out, `CL_SIZE`, that way's state after update.

## Operation
- **States:** IDLE, READ, EVAL, ALLOC, RESP.
- **IDLE:** `req_ready`=1 only in IDLE. On `req_valid & req_ready`, latch tag, set, op, src and dest, then go to READ.
- **READ:** register the set's tag and state arrays into the set buffer. Compute the valid match: `tag == lane` and `state != 0`.
  - With a valid match, `resp_way` is the highest matching index and `resp_hit`=1. Go to EVAL.
  - Without a valid match, `resp_hit`=0 and `resp_way` is the lowest way with state 0. Go to ALLOC.
  - Without a valid match and no invalid way, `resp_full`=1 and `resp_way`=0. Go to RESP with no array write.
- **Lane masking:** the `sel_tag_state` lane of every way with state 0 is driven as `~sel_tag`, except the way being allocated. This guarantees a single match in the select stage.
- **ALLOC:** write the latched tag into `tag_array[set][resp_way]` and into the set buffer. Go to EVAL. That way's state stays 0, so the select stage computes the state from invalid.
- **EVAL:** the `sel_*` outputs are stable. At the end of the cycle, write `sel_data_next` into `state_array[set]` and capture `resp_state` = lane `resp_way`. Go to RESP.
- **RESP:** `resp_valid`=1. The payload is held stable until `resp_ready`. On handshake, go to IDLE.
- **Unused input:** the select stage's tag-next output is not consumed. Tags change only through ALLOC.
- **Outputs outside EVAL:** `sel_*` reflect the latched request and set buffer, but downstream values are don't-care.

## Timing
- **Reset:** `rst`=0 asynchronously clears all tag and state arrays to 0, sets FSM=IDLE, and clears all latches. Outputs during reset: `req_ready`=1, `resp_valid`=0, `resp_hit`=0, `resp_full`=0, `resp_way`=0, `resp_state`=0, all `sel_*`=0.
- **Reset mid-operation:** an in-flight request is dropped and no partial write survives.
- **Hit:** accept at edge 0, READ in cycle 1, EVAL in cycle 2, `resp_valid` in cycle 3.
- **Miss with allocate:** READ, ALLOC, EVAL, then `resp_valid` in cycle 4.
- **Full:** `resp_valid` in cycle 2.
- **Back-to-back:** earliest next acceptance is the cycle after the response handshake. `req_ready` rises in the same cycle as the return to IDLE.
- **Same-set requests:** no hazard is possible, because only one request is in flight and writes complete before RESP.
- **Ignored inputs:** `req_valid` outside IDLE is ignored. `resp_ready` outside RESP is ignored.

## Test plan
- **Reset:** assert `rst`=0 mid-EVAL. Required: immediately `resp_valid`=0 and `req_ready`=1. A lookup of the same address after reset misses and allocates way 0.
- **Miss-allocate:** empty set 5, request tag `0x1234`, select stage returns way0=`4'h2`. Required: `resp_hit`=0, `resp_way`=0, `resp_state`=2, response in cycle 4. A repeat request gives `resp_hit`=1, `resp_way`=0, response in cycle 3.
- **Masking:** set 3 with way 2 valid at tag `0x0`, all others invalid, tag 0 requested. Required: `sel_tag_state` lanes 0, 1 and 3..7 equal `~0`, and `resp_way`=2.
- **Full:** fill all 8 ways of set 9 with distinct tags, then request a 9th tag. Required: `resp_full`=1, `resp_way`=0, response in cycle 2, arrays unchanged.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles on a hit. Required: payload stable, `req_ready`=0, and the next request is accepted only after the handshake.
- **Multiple valid matches:** ways 1 and 6 hold the same tag, both valid (forced). Required: `resp_way`=6.
